// File: rtl/board_if.sv
// Board store interface: keyboard/new-game inputs from the game side,
// occupancy and move status back out to the colour mapper and controller.
interface board_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [7:0]           keycode;
  logic                 new_game;
  logic [ROWS*COLS-1:0] red_occ;
  logic [ROWS*COLS-1:0] black_occ;
  logic                 turn;
  logic                 move_valid;
  logic                 move_invalid;
  logic [CW-1:0]        last_col;
  logic [RW-1:0]        last_row;
  logic                 board_full;

  modport master (
    output keycode, new_game,
    input  red_occ, black_occ, turn, move_valid, move_invalid,
           last_col, last_row, board_full
  );

  modport slave (
    input  keycode, new_game,
    output red_occ, black_occ, turn, move_valid, move_invalid,
           last_col, last_row, board_full
  );
endinterface

// File: rtl/board_state.sv
// Connect Four board store: decodes column keys, drops one piece per key
// press into the lowest free cell, alternates turns, flags full columns.
//
// state      | meaning
// S_IDLE     | waiting for a column key
// S_DROP     | commit or reject the latched column (one cycle)
// S_WAIT_REL | wait for keycode 8'h00 before accepting another key
module board_state #(
  parameter int         ROWS     = 6,
  parameter int         COLS     = 7,
  parameter logic [7:0] KEY_COL0 = 8'h1E,
  parameter logic       FIRST    = 1'b0
) (
  input  logic     frame_clk,
  input  logic     Reset,
  board_if.slave   bif
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HW = $clog2(ROWS + 1);
  localparam int NC = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_WAIT_REL} state_e;

  state_e          state_q, state_d;
  logic [NC-1:0]   red_q, red_d;
  logic [NC-1:0]   black_q, black_d;
  logic [HW-1:0]   height_q [COLS];
  logic [HW-1:0]   height_d [COLS];
  logic [CW-1:0]   sel_col_q, sel_col_d;
  logic            turn_q, turn_d;
  logic            mv_q, mv_d;
  logic            mi_q, mi_d;
  logic [CW-1:0]   last_col_q, last_col_d;
  logic [RW-1:0]   last_row_q, last_row_d;
  logic            full_q;

  logic            clear;
  logic            key_hit;
  logic [7:0]      key_off;
  logic [HW-1:0]   sel_height;
  logic            drop_ok;

  assign clear   = Reset | bif.new_game;
  // 9-bit compare so KEY_COL0+COLS cannot wrap past 8'hFF
  assign key_hit = ({1'b0, bif.keycode} >= {1'b0, KEY_COL0}) &&
                   ({1'b0, bif.keycode} <  ({1'b0, KEY_COL0} + 9'(COLS)));
  assign key_off = bif.keycode - KEY_COL0;
  assign sel_height = height_q[sel_col_q];
  assign drop_ok    = sel_height < HW'(ROWS);

  // State register; clear from either source returns to idle
  always_ff @(posedge frame_clk) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one drop per press, release required before the next
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (key_hit) state_d = S_DROP;
      S_DROP:     state_d = S_WAIT_REL;
      S_WAIT_REL: if (bif.keycode == 8'h00) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: latch column in idle, commit or reject in drop
  always_comb begin
    red_d      = red_q;
    black_d    = black_q;
    height_d   = height_q;
    sel_col_d  = sel_col_q;
    turn_d     = turn_q;
    mv_d       = 1'b0;
    mi_d       = 1'b0;
    last_col_d = last_col_q;
    last_row_d = last_row_q;
    if (state_q == S_IDLE && key_hit) sel_col_d = key_off[CW-1:0];
    if (state_q == S_DROP) begin
      if (drop_ok) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (r == int'(sel_height) && c == int'(sel_col_q)) begin
              if (turn_q) black_d[r*COLS+c] = 1'b1;
              else        red_d[r*COLS+c]   = 1'b1;
            end
          end
        end
        height_d[sel_col_q] = sel_height + HW'(1);
        turn_d     = ~turn_q;
        mv_d       = 1'b1;
        last_col_d = sel_col_q;
        last_row_d = sel_height[RW-1:0];
      end else begin
        mi_d = 1'b1;
      end
    end
  end

  // Board and status registers; clear discards any pending drop
  always_ff @(posedge frame_clk) begin
    if (clear) begin
      red_q      <= '0;
      black_q    <= '0;
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
      sel_col_q  <= '0;
      turn_q     <= FIRST;
      mv_q       <= 1'b0;
      mi_q       <= 1'b0;
      last_col_q <= '0;
      last_row_q <= '0;
      full_q     <= 1'b0;
    end else begin
      red_q      <= red_d;
      black_q    <= black_d;
      height_q   <= height_d;
      sel_col_q  <= sel_col_d;
      turn_q     <= turn_d;
      mv_q       <= mv_d;
      mi_q       <= mi_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
      // looks at the registered board, so it trails the last drop by a cycle
      full_q     <= &(red_q | black_q);
    end
  end

  assign bif.red_occ      = red_q;
  assign bif.black_occ    = black_q;
  assign bif.turn         = turn_q;
  assign bif.move_valid   = mv_q;
  assign bif.move_invalid = mi_q;
  assign bif.last_col     = last_col_q;
  assign bif.last_row     = last_row_q;
  assign bif.board_full   = full_q;

endmodule
